// File: rtl/alu3_pipe.sv
// Pipelined three-operand unsigned adder/subtractor with accumulate mode.
// Results carry a valid tag through PIPE_STAGES registers; i_hold freezes everything.
module alu3_pipe #(
  parameter int WIDTH       = 14,
  parameter int PIPE_STAGES = 2,
  parameter bit SATURATE    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic             i_clr,
  input  logic             i_hold,
  output logic [WIDTH-1:0] o_1,
  output logic             o_valid,
  output logic             o_ovf
);

  // Handshake: a beat is taken on any rising edge with i_valid=1, i_hold=0, rst=0;
  // it leaves with o_valid=1 after PIPE_STAGES-1 further non-held edges. No backpressure.

  // Three guard bits keep acc+a+b+c and a-b-c exact in two's complement.
  localparam int XW = WIDTH + 3;

  logic [WIDTH-1:0]       r_acc;
  logic [WIDTH-1:0]       r_data [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] r_valid;
  logic [PIPE_STAGES-1:0] r_ovf;

  logic [XW-1:0]    w_a;
  logic [XW-1:0]    w_b;
  logic [XW-1:0]    w_c;
  logic [XW-1:0]    w_base;
  logic [XW-1:0]    w_sum;
  logic             w_under;
  logic             w_over;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

  always_comb begin
    w_a    = {3'b000, i_a};
    w_b    = {3'b000, i_b};
    w_c    = {3'b000, i_c};
    w_base = i_clr ? '0 : {3'b000, r_acc};
    case (i_mode)
      2'b00:   w_sum = w_a + w_b + w_c;
      2'b01:   w_sum = w_a + w_b - w_c;
      2'b10:   w_sum = w_a - w_b - w_c;
      default: w_sum = w_base + w_a + w_b + w_c;
    endcase
    w_under = w_sum[XW-1];
    w_over  = !w_sum[XW-1] && (w_sum[XW-2:WIDTH] != 2'b00);
    w_ovf   = w_under || w_over;
    if (SATURATE && w_under) begin
      w_res = '0;
    end else if (SATURATE && w_over) begin
      w_res = '1;
    end else begin
      w_res = w_sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_valid <= '0;
      r_ovf   <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_data[s] <= '0;
      end
    end else if (!i_hold) begin
      r_valid[0] <= i_valid;
      // Bubbles keep the previous data fields so o_1 holds its last result.
      if (i_valid) begin
        r_data[0] <= w_res;
        r_ovf[0]  <= w_ovf;
      end
      if (i_valid && i_mode == 2'b11) begin
        r_acc <= w_res;
      end else if (i_clr) begin
        r_acc <= '0;
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_data[s]  <= r_data[s-1];
        r_ovf[s]   <= r_ovf[s-1];
      end
    end
  end

  assign o_1     = r_data[PIPE_STAGES-1];
  assign o_valid = r_valid[PIPE_STAGES-1];
  assign o_ovf   = r_ovf[PIPE_STAGES-1];

endmodule

// File: tb/tb_alu3_pipe.sv
// Bench for alu3_pipe: vector table plus hand sequences for accumulate, hold and reset.
module tb_alu3_pipe;
  localparam int W = 14;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic [1:0]   i_mode = 2'b00;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic [W-1:0] i_c = '0;
  logic         i_clr = 1'b0;
  logic         i_hold = 1'b0;
  logic [W-1:0] o_1;
  logic         o_valid;
  logic         o_ovf;
  logic [W-1:0] w_o1;
  logic         w_valid;
  logic         w_ovf;

  alu3_pipe #(.WIDTH(W), .PIPE_STAGES(P), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_mode(i_mode),
    .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_clr(i_clr), .i_hold(i_hold),
    .o_1(o_1), .o_valid(o_valid), .o_ovf(o_ovf)
  );

  alu3_pipe #(.WIDTH(W), .PIPE_STAGES(P), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_mode(i_mode),
    .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_clr(i_clr), .i_hold(i_hold),
    .o_1(w_o1), .o_valid(w_valid), .o_ovf(w_ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int adv   = 0;
  logic r_live = 1'b0;

  // scoreboard: {ovf, result} and the advancing-edge count at which it must appear
  logic [W:0] exp_q[$];
  int         due_q[$];

  always @(posedge clk) begin
    r_live <= !rst && !i_hold;
    if (!rst && !i_hold) adv <= adv + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (r_live && exp_q.size() > 0 && due_q[0] == adv) begin
      logic [W:0] e;
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      check("o_valid", 32'(o_valid), 32'd1);
      check("o_1", 32'(o_1), 32'(e[W-1:0]));
      check("o_ovf", 32'(o_ovf), 32'(e[W]));
    end else if (r_live && o_valid) begin
      check("unexpected_valid", 32'(o_valid), 32'd0);
    end
  end

  // driver
  task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c, input logic clr,
                       input logic hold, input logic [W-1:0] e, input logic eo);
    @(posedge clk);
    #2;
    i_valid = v; i_mode = m; i_a = a; i_b = b; i_c = c; i_clr = clr; i_hold = hold;
    if (v && !hold) begin
      exp_q.push_back({eo, e});
      due_q.push_back(adv + P);
    end
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst = 1'b1; i_valid = 1'b0; i_clr = 1'b0; i_hold = 1'b0;
    @(posedge clk);
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_1", 32'(o_1), 32'd0);
    check("rst_o_ovf", 32'(o_ovf), 32'd0);
    #1;
    rst = 1'b0;
    exp_q.delete();
    due_q.delete();
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] exp;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'b00, 14'd1,     14'd4,   14'd3,  14'd8,     1'b0};
    vecs[1] = '{2'b00, 14'd4,     14'd5,   14'd9,  14'd18,    1'b0};
    vecs[2] = '{2'b01, 14'd4,     14'd5,   14'd9,  14'd0,     1'b0};
    vecs[3] = '{2'b01, 14'd4,     14'd5,   14'd10, 14'd0,     1'b1};
    vecs[4] = '{2'b10, 14'd100,   14'd30,  14'd20, 14'd50,    1'b0};
    vecs[5] = '{2'b00, 14'd16383, 14'd1,   14'd0,  14'd16383, 1'b1};
    vecs[6] = '{2'b00, 14'd16000, 14'd383, 14'd0,  14'd16383, 1'b0};
    vecs[7] = '{2'b10, 14'd0,     14'd1,   14'd0,  14'd0,     1'b1};

    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("por_o_valid", 32'(o_valid), 32'd0);
    check("por_o_1", 32'(o_1), 32'd0);
    check("por_o_ovf", 32'(o_ovf), 32'd0);
    #1;
    rst = 1'b0;

    // single beat latency: sampled at edge k, visible after edge k+P-1
    drive(1'b1, 2'b00, 14'd1, 14'd4, 14'd3, 1'b0, 1'b0, 14'd8, 1'b0);
    idle();
    #1;
    check("lat_after_sample", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_out_valid", 32'(o_valid), 32'd1);
    check("lat_out_data", 32'(o_1), 32'd8);
    @(posedge clk);
    #1;
    check("lat_one_cycle", 32'(o_valid), 32'd0);
    check("bubble_keeps_o_1", 32'(o_1), 32'd8);

    // back-to-back table
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, 1'b0,
            vecs[i].exp, vecs[i].exp_ovf);
    end
    idle();
    idle();

    // wrap variant on overflow
    drive(1'b1, 2'b00, 14'd16383, 14'd1, 14'd0, 1'b0, 1'b0, 14'd16383, 1'b1);
    idle();
    @(posedge clk);
    #1;
    check("wrap_valid", 32'(w_valid), 32'd1);
    check("wrap_o_1", 32'(w_o1), 32'd0);
    check("wrap_ovf", 32'(w_ovf), 32'd1);

    // accumulate
    drive(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 2'b11, 14'd1, 14'd4, 14'd3, 1'b0, 1'b0, 14'd8, 1'b0);
    drive(1'b1, 2'b11, 14'd4, 14'd5, 14'd9, 1'b0, 1'b0, 14'd26, 1'b0);
    idle();
    drive(1'b1, 2'b11, 14'd0, 14'd0, 14'd0, 1'b0, 1'b0, 14'd26, 1'b0);
    drive(1'b1, 2'b11, 14'd2, 14'd0, 14'd0, 1'b1, 1'b0, 14'd2, 1'b0);
    drive(1'b1, 2'b00, 14'd7, 14'd7, 14'd7, 1'b0, 1'b0, 14'd21, 1'b0);
    drive(1'b1, 2'b11, 14'd1, 14'd0, 14'd0, 1'b0, 1'b0, 14'd3, 1'b0);
    drive(1'b1, 2'b11, 14'd16383, 14'd0, 14'd0, 1'b1, 1'b0, 14'd16383, 1'b0);
    drive(1'b1, 2'b11, 14'd16383, 14'd0, 14'd0, 1'b0, 1'b0, 14'd16383, 1'b1);
    idle();
    idle();

    // hold: beats presented while held must vanish
    drive(1'b1, 2'b00, 14'd1, 14'd1, 14'd1, 1'b0, 1'b0, 14'd3, 1'b0);
    drive(1'b1, 2'b00, 14'd2, 14'd2, 14'd2, 1'b0, 1'b0, 14'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 14'd7, 14'd7, 14'd7, 1'b1, 1'b1, '0, 1'b0);
      if (i > 0) begin
        check("hold_o_1", 32'(o_1), 32'd3);
        check("hold_o_valid", 32'(o_valid), 32'd1);
      end
    end
    drive(1'b1, 2'b00, 14'd3, 14'd3, 14'd3, 1'b0, 1'b0, 14'd9, 1'b0);
    check("hold_o_1_last", 32'(o_1), 32'd3);
    drive(1'b1, 2'b00, 14'd4, 14'd4, 14'd4, 1'b0, 1'b0, 14'd12, 1'b0);
    idle();
    idle();

    // reset with acc at 26 and a beat in stage 1
    drive(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 2'b11, 14'd1, 14'd4, 14'd3, 1'b0, 1'b0, 14'd8, 1'b0);
    drive(1'b1, 2'b11, 14'd4, 14'd5, 14'd9, 1'b0, 1'b0, 14'd26, 1'b0);
    drive(1'b1, 2'b11, 14'd0, 14'd0, 14'd0, 1'b0, 1'b0, 14'd26, 1'b0);
    pulse_reset();
    drive(1'b1, 2'b11, 14'd1, 14'd0, 14'd0, 1'b0, 1'b0, 14'd1, 1'b0);
    repeat (4) idle();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
